freq_sweep_analyzer: RTL and testbench
======================================

Name: freq_sweep_analyzer

Overview:
- Hardware consumer at the far end of the sine_gen → cascade_low_pass_filter chain.
- Sweeps the sine_gen period, holds the generator and filter in reset between points, and waits for settling.
- Measures signed min/max of the filter output over a window of whole oscillations.
- Emits one result record per period over a valid/ready handshake, so filter frequency response is measured on-chip instead of dumped by a bench.

Parameters:
- word_width, 16, filter sample width (two's complement)
- period_width, 32, width of period, step and stop values
- lut_steps, 1024, sine_gen LUT steps per oscillation (power of 2)
- skip_osc, 2, oscillations discarded after gen reset release
- meas_osc, 8, oscillations measured per point
- settle_cycles, 100, cycles gen_rst held high before each point

Ports:
- clk  in  1  system clock (250 MHz)
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins sweep, ignored while busy
- period_start  in  period_width  first period
- period_step  in  period_width  increment per point
- period_stop  in  period_width  last period (inclusive)
- period_out  out  period_width  period to sine_gen
- gen_rst  out  1  active-high reset to sine_gen and filters
- sample_in  in  word_width  signed filter output
- sample_valid  in  1  sample_in qualifier
- res_valid  out  1  result record valid
- res_ready  in  1  downstream accepts record
- res_period  out  period_width  period of this record
- res_max  out  word_width  signed max in window
- res_min  out  word_width  signed min in window
- res_pp  out  word_width+1  unsigned res_max - res_min
- res_no_data  out  1  no valid sample occurred in window
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset state: state IDLE, all outputs 0 except gen_rst=1. Async assertion aborts any sweep immediately; a record in flight is lost.
- IDLE
  - gen_rst=1, busy=0.
  - On start: latch start/step/stop, period_out=max(period_start,1), go to SETTLE.
- SETTLE
  - gen_rst=1 for exactly settle_cycles cycles, then go to SKIP.
  - Min/max trackers clear to max=most-negative, min=most-positive, no_data=1.
- SKIP
  - gen_rst=0 for period_out*lut_steps*skip_osc cycles; samples ignored.
- MEASURE
  - gen_rst=0 for period_out*lut_steps*meas_osc cycles.
  - Each cycle with sample_valid updates max/min and clears no_data.
  - Samples arriving in the cycle of exit to REPORT are excluded.
  - Window counter width is period_width+log2(lut_steps)+4, so it cannot overflow.
- REPORT
  - gen_rst=1, res_valid=1.
  - res_* stay stable until res_ready; transfer when res_valid&&res_ready.
  - If no_data: res_max=res_min=res_pp=0, res_no_data=1.
  - After transfer, next = period_out + period_step, computed at period_width+1 bits.
    - If step==0, next>period_stop, or carry-out: done=1 for one cycle, go to IDLE.
    - Otherwise period_out=next, go to SETTLE.
  - res_valid deasserts the cycle after transfer.
- res_ready stalled indefinitely: hold REPORT with gen_rst=1; nothing dropped.
- period_start>period_stop: exactly one point is measured, then done.
- start during busy: ignored, no effect.
- res_pp: computed at word_width+1 bits, so the full range gives 2^word_width-1.

Optional Feature:
- Macro: FREQ_SWEEP_MEAN_EN.
- Defined:
  - Adds outputs res_sum (signed, word_width+period_width+14 bits) and res_count (period_width+14 bits).
  - These are the sum and count of valid samples in the MEASURE window, cleared in SETTLE and presented with the record.
  - DC offset equals res_sum/res_count, computed offline.
- Undefined: these ports and accumulators do not exist; all other behaviour is identical.

Decomposition:
- opo_package holds:
  - fsa_state_t enum: IDLE, SETTLE, SKIP, MEASURE, REPORT
  - LUT_STEPS constant
  - fsa_result_t packed struct: period, max, min, pp, no_data
- One sub-module: minmax_tracker.
  - Inputs: clear, sample, valid.
  - Outputs: max, min, no_data.
  - Registered; one-cycle update latency.

Test Plan:
- start with start=2, step=5, stop=12, res_ready=1, ideal sine ±32767 input → 3 records with periods 2, 7, 12; each res_pp=65534; done pulses once; gen_rst high in SETTLE and REPORT only.
- Cycle count for period=3 with defaults → SETTLE 100 cycles, SKIP 6144, MEASURE 24576, checked against gen_rst edges.
- res_ready held low 500 cycles in REPORT → res_valid stays high, fields stable, gen_rst=1; a single transfer on release.
- sample_valid=0 throughout → res_no_data=1, res_max=res_min=res_pp=0.
- step=0 with start=5, stop=100 → exactly one record (period 5), then done; start=2^32-2, step=5, stop=2^32-1 → one record, carry ends sweep.
- rst asserted mid-MEASURE then a new start → outputs zero immediately; the new sweep begins at the new period_start, with no residual min/max.

Source files
------------

// File: rtl/freq_sweep_analyzer_pkg.sv
// Shared types for the frequency sweep analyzer: FSM states,
// LUT step count and the per-period result record.
package freq_sweep_analyzer_pkg;

    localparam int LUT_STEPS    = 1024;
    localparam int REC_WORD_W   = 16;
    localparam int REC_PERIOD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SKIP,
        MEASURE,
        REPORT
    } fsa_state_t;

    typedef struct packed {
        logic [REC_PERIOD_W-1:0]      period;
        logic signed [REC_WORD_W-1:0] max;
        logic signed [REC_WORD_W-1:0] min;
        logic [REC_WORD_W:0]          pp;
        logic                         no_data;
    } fsa_result_t;

endpackage

// File: rtl/freq_sweep_analyzer_minmax_tracker.sv
// Registered signed min/max tracker with a no-data flag.
// Clear loads max=most-negative, min=most-positive.
module minmax_tracker
    import freq_sweep_analyzer_pkg::*;
#(
    parameter int word_width = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic signed [word_width-1:0] sample,
    input  logic                         valid,
    output logic signed [word_width-1:0] max,
    output logic signed [word_width-1:0] min,
    output logic                         no_data
);

    localparam logic signed [word_width-1:0] MOST_NEG =
        {1'b1, {(word_width-1){1'b0}}};
    localparam logic signed [word_width-1:0] MOST_POS =
        {1'b0, {(word_width-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max     <= MOST_NEG;
            min     <= MOST_POS;
            no_data <= 1'b1;
        end else if (clear) begin
            max     <= MOST_NEG;
            min     <= MOST_POS;
            no_data <= 1'b1;
        end else if (valid) begin
            if (sample > max) max <= sample;
            if (sample < min) min <= sample;
            no_data <= 1'b0;
        end
    end

endmodule

// File: rtl/freq_sweep_analyzer.sv
// Sweeps sine_gen period, measures filter output min/max per point.
// FREQ_SWEEP_MEAN_EN adds per-window sample sum/count outputs.
module freq_sweep_analyzer
    import freq_sweep_analyzer_pkg::*;
#(
    parameter int word_width    = 16,
    parameter int period_width  = 32,
    parameter int lut_steps     = LUT_STEPS,
    parameter int skip_osc      = 2,
    parameter int meas_osc      = 8,
    parameter int settle_cycles = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [period_width-1:0]        period_start,
    input  logic [period_width-1:0]        period_step,
    input  logic [period_width-1:0]        period_stop,
    output logic [period_width-1:0]        period_out,
    output logic                           gen_rst,
    input  logic signed [word_width-1:0]   sample_in,
    input  logic                           sample_valid,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [period_width-1:0]        res_period,
    output logic signed [word_width-1:0]   res_max,
    output logic signed [word_width-1:0]   res_min,
    output logic [word_width:0]            res_pp,
    output logic                           res_no_data,
`ifdef FREQ_SWEEP_MEAN_EN
    output logic signed [word_width+period_width+13:0] res_sum,
    output logic [period_width+13:0]       res_count,
`endif
    output logic                           busy,
    output logic                           done
);

    localparam int LOG_STEPS = $clog2(lut_steps);
    localparam int CNT_W     = period_width + LOG_STEPS + 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(settle_cycles - 1);

    fsa_state_t state, state_n;
    fsa_result_t rec;

    logic [CNT_W-1:0]        cnt, osc_len, skip_last, meas_last;
    logic [period_width-1:0] period_q, step_q, stop_q;
    logic [period_width:0]   next_period;
    logic [word_width:0]     pp_w;
    logic                    last, xfer, finish, track;
    logic signed [word_width-1:0] trk_max, trk_min;
    logic                    trk_no_data;

    assign osc_len   = CNT_W'(period_q) << LOG_STEPS;
    assign skip_last = osc_len * CNT_W'(skip_osc) - CNT_W'(1);
    assign meas_last = osc_len * CNT_W'(meas_osc) - CNT_W'(1);

    assign next_period = {1'b0, period_q} + {1'b0, step_q};
    assign finish = (step_q == '0) || next_period[period_width] ||
                    (next_period[period_width-1:0] > stop_q);
    assign xfer = (state == REPORT) && res_ready;

    always_comb begin
        state_n = state;
        last    = 1'b0;
        case (state)
            IDLE: if (start) state_n = SETTLE;
            SETTLE: begin
                last = (cnt == SETTLE_LAST);
                if (last) state_n = SKIP;
            end
            SKIP: begin
                last = (cnt == skip_last);
                if (last) state_n = MEASURE;
            end
            MEASURE: begin
                last = (cnt == meas_last);
                if (last) state_n = REPORT;
            end
            REPORT: if (xfer) state_n = finish ? IDLE : SETTLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            period_q <= '0;
            step_q   <= '0;
            stop_q   <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n == state) ? cnt + CNT_W'(1) : '0;
            done  <= xfer && finish;
            if (state == IDLE && start) begin
                period_q <= (period_start == '0) ?
                            period_width'(1) : period_start;
                step_q   <= period_step;
                stop_q   <= period_stop;
            end else if (xfer && !finish) begin
                period_q <= next_period[period_width-1:0];
            end
        end
    end

    // The final MEASURE cycle is excluded so the record is frozen in REPORT.
    assign track = sample_valid && (state == MEASURE) && !last;

    minmax_tracker #(
        .word_width(word_width)
    ) u_trk (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == SETTLE),
        .sample  (sample_in),
        .valid   (track),
        .max     (trk_max),
        .min     (trk_min),
        .no_data (trk_no_data)
    );

    assign pp_w = {trk_max[word_width-1], trk_max} -
                  {trk_min[word_width-1], trk_min};

    always_comb begin
        rec = '0;
        if (state == REPORT) begin
            rec.period  = REC_PERIOD_W'(period_q);
            rec.no_data = trk_no_data;
            if (!trk_no_data) begin
                rec.max = REC_WORD_W'(trk_max);
                rec.min = REC_WORD_W'(trk_min);
                rec.pp  = (REC_WORD_W+1)'(pp_w);
            end
        end
    end

    assign period_out  = period_q;
    assign gen_rst     = !(state == SKIP || state == MEASURE);
    assign busy        = (state != IDLE);
    assign res_valid   = (state == REPORT);
    assign res_period  = period_width'(rec.period);
    assign res_max     = word_width'(rec.max);
    assign res_min     = word_width'(rec.min);
    assign res_pp      = (word_width+1)'(rec.pp);
    assign res_no_data = rec.no_data;

`ifdef FREQ_SWEEP_MEAN_EN
    localparam int SUM_W = word_width + period_width + 14;
    localparam int NUM_W = period_width + 14;

    logic signed [SUM_W-1:0] sum_q;
    logic [NUM_W-1:0]        count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            count_q <= '0;
        end else if (state == SETTLE) begin
            sum_q   <= '0;
            count_q <= '0;
        end else if (track) begin
            sum_q   <= sum_q + SUM_W'(sample_in);
            count_q <= count_q + NUM_W'(1);
        end
    end

    assign res_sum   = res_valid ? sum_q : '0;
    assign res_count = res_valid ? count_q : '0;
`endif

endmodule

// File: tb/tb_freq_sweep_analyzer.sv
// Scoreboard bench for freq_sweep_analyzer with a small LUT and period width.
module tb_freq_sweep_analyzer;

    localparam int WW   = 16;
    localparam int PW   = 8;
    localparam int LS   = 8;
    localparam int SKO  = 2;
    localparam int MEO  = 8;
    localparam int SET  = 100;
    localparam int NLOG = 100000;

    logic clk = 0, rst = 1, start = 0;
    logic [PW-1:0] period_start = '0, period_step = '0, period_stop = '0;
    logic [PW-1:0] period_out;
    logic gen_rst;
    logic signed [WW-1:0] sample_in = '0;
    logic sample_valid = 0;
    logic res_valid, res_ready = 1;
    logic [PW-1:0] res_period;
    logic signed [WW-1:0] res_max, res_min;
    logic [WW:0] res_pp;
    logic res_no_data, busy, done;
`ifdef FREQ_SWEEP_MEAN_EN
    logic signed [WW+PW+13:0] res_sum;
    logic [PW+13:0] res_count;
`endif

    freq_sweep_analyzer #(
        .word_width(WW), .period_width(PW), .lut_steps(LS),
        .skip_osc(SKO), .meas_osc(MEO), .settle_cycles(SET)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .period_start(period_start), .period_step(period_step),
        .period_stop(period_stop), .period_out(period_out),
        .gen_rst(gen_rst), .sample_in(sample_in),
        .sample_valid(sample_valid), .res_valid(res_valid),
        .res_ready(res_ready), .res_period(res_period),
        .res_max(res_max), .res_min(res_min), .res_pp(res_pp),
        .res_no_data(res_no_data),
`ifdef FREQ_SWEEP_MEAN_EN
        .res_sum(res_sum), .res_count(res_count),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input string msg);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
    endtask

    // Stimulus log: value presented at the posedge with that index.
    int smp [NLOG];
    bit vld [NLOG];
    int mode = 0;
    int stall_left = 0;
    bit rnd_ready = 0;

    always @(posedge clk) begin
        int idx, v, n;
        bit sv;
        real rv;
        #1;
        idx = cyc + 1;
        v = 0;
        sv = 0;
        case (mode)
            0: begin
                v = int'($urandom_range(0, 65535)) - 32768;
                sv = 1'($urandom_range(0, 1));
            end
            1: begin
                n = (period_out == '0) ? LS : int'(period_out) * LS;
                rv = 32767.0 * $sin(6.283185307179586 * real'(idx % n) / real'(n));
                v = (rv >= 0.0) ? $rtoi(rv + 0.5) : -$rtoi(0.5 - rv);
                sv = 1;
            end
            3: begin
                v = int'($urandom_range(0, 200)) - 100;
                sv = 1'($urandom_range(0, 1));
            end
            4: begin
                v = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                sv = 1;
            end
            default: begin
                v = int'($urandom_range(0, 65535)) - 32768;
                sv = 0;
            end
        endcase
        if (idx < NLOG) begin
            smp[idx] = v;
            vld[idx] = sv;
        end
        sample_in = WW'(v);
        sample_valid = sv;
        if (res_valid && stall_left > 0) begin
            res_ready = 0;
            stall_left--;
        end else begin
            res_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    typedef struct {
        longint period;
        bit last;
    } exp_t;
    exp_t exp_q[$];

    longint anchor = 0, fall_at = -1, done_at = -1;
    bit in_rep = 0, prev_g = 1, changed = 0, sweep_done = 0, full_pp = 0;
    logic [PW+3*WW+1:0] cur, snap;
    longint emax, emin, p, k, m;
    bit enod;

    // Reference: extremes over valid samples of the measure window.
    function automatic void win_model(input longint lo, input longint hi,
                                      output longint mx, output longint mn,
                                      output bit nd);
        mx = -32768;
        mn = 32767;
        nd = 1;
        for (longint i = lo; i <= hi; i++) begin
            if (i < NLOG && vld[i]) begin
                nd = 0;
                if (smp[i] > mx) mx = smp[i];
                if (smp[i] < mn) mn = smp[i];
            end
        end
        if (nd) begin
            mx = 0;
            mn = 0;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_rep = 0;
            prev_g = 1;
        end else begin
            if (prev_g && !gen_rst) fall_at = cyc;
            prev_g = gen_rst;
            if (done) begin
                chk("done_cycle", cyc, done_at);
                chk("done_busy", busy, 0);
                sweep_done = 1;
                done_at = -1;
            end else if (cyc == done_at) begin
                fail_now("done_missing", "no done pulse after last record");
                done_at = -1;
            end
            if (in_rep && !res_valid) begin
                fail_now("valid_dropped", "res_valid fell before transfer");
                in_rep = 0;
            end
            if (res_valid) begin
                cur = {res_period, res_max, res_min, res_pp, res_no_data};
                if (!in_rep) begin
                    in_rep = 1;
                    snap = cur;
                    changed = !gen_rst || !busy;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_record", "record with empty scoreboard");
                    end else begin
                        p = exp_q[0].period;
                        k = p * LS * SKO;
                        m = p * LS * MEO;
                        chk("report_cycle", cyc, anchor + SET + k + m);
                        chk("skip_start", fall_at, anchor + SET);
                        win_model(anchor + SET + k + 1, anchor + SET + k + m - 1,
                                  emax, emin, enod);
                    end
                end else if (cur != snap || !gen_rst || !busy) begin
                    changed = 1;
                end
                if (res_ready) begin
                    in_rep = 0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rec_period", res_period, e.period);
                        chk("rec_max", res_max, emax);
                        chk("rec_min", res_min, emin);
                        chk("rec_pp", res_pp, emax - emin);
                        chk("rec_no_data", res_no_data, enod);
                        chk("rec_stable", changed, 0);
                        if (full_pp) chk("rec_pp_full", res_pp, 65534);
                        anchor = cyc + 1;
                        if (e.last) done_at = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic sweep(input longint s, input longint st, input longint sp);
        longint q, nx;
        exp_t e;
        q = (s == 0) ? 1 : s;
        forever begin
            nx = q + st;
            e.period = q;
            e.last = (st == 0) || (nx > sp) || (nx >= (longint'(1) << PW));
            exp_q.push_back(e);
            if (e.last) break;
            q = nx;
        end
        @(posedge clk);
        #1;
        period_start = PW'(s);
        period_step = PW'(st);
        period_stop = PW'(sp);
        start = 1;
        anchor = cyc + 1;
        sweep_done = 0;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic recover();
        rst = 1;
        @(posedge clk);
        #1;
        exp_q.delete();
        in_rep = 0;
        done_at = -1;
        rst = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!sweep_done && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (!sweep_done) begin
            fail_now("sweep_timeout", "done pulse not seen within budget");
            recover();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gen_rst", gen_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_period_out", period_out, 0);
        chk("reset_done", done, 0);
        chk("reset_res_pp", res_pp, 0);
        @(posedge clk);
        #1;
        rst = 0;

        mode = 1;
        full_pp = 1;
        sweep(2, 5, 12);
        wait_done(6000);
        full_pp = 0;

        mode = 0;
        sweep(3, 1, 2);
        wait_done(2000);

        stall_left = 500;
        sweep(4, 0, 9);
        wait_done(3000);
        stall_left = 0;

        mode = 2;
        sweep(0, 3, 5);
        wait_done(3000);

        mode = 0;
        sweep(5, 0, 100);
        wait_done(2000);

        for (int r = 0; r < 3; r++) begin
            rnd_ready = 1;
            mode = ($urandom_range(0, 1) != 0) ? 0 : 3;
            sweep($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 10));
            repeat (150) @(posedge clk);
            #1;
            period_start = PW'($urandom_range(20, 200));
            period_step = PW'($urandom_range(0, 9));
            period_stop = PW'($urandom_range(0, 255));
            start = 1;
            @(posedge clk);
            #1;
            start = 0;
            wait_done(20000);
        end
        rnd_ready = 0;

        mode = 0;
        sweep(254, 5, 255);
        wait_done(25000);

        mode = 4;
        sweep(3, 0, 3);
        n = 0;
        while (cyc < anchor + SET + 3 * LS * SKO + 3 * LS * MEO / 2 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #3;
        rst = 1;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gen_rst", gen_rst, 1);
        chk("abort_period_out", period_out, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        in_rep = 0;
        done_at = -1;
        @(posedge clk);
        #1;
        rst = 0;
        mode = 3;
        sweep(2, 0, 0);
        wait_done(2000);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
